perf_monitor: RTL and testbench

Hardware performance monitor for the superscalar RISC-V vector core. It counts cycles, committed instructions, committed branches and mispredict flushes over a software- or bench-delimited measurement window. The window closes automatically when a stable WFI is detected in decode. It sits beside the processor and taps the ROB's two writeback/commit slots, the decode flush and the two decoder WFI flags. Results are exposed through a simple registered read port.

---
 rtl/perf_monitor.sv | 171 +++++++++++++++++
 tb/tb_perf_monitor.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// perf_monitor: counts cycles, committed instructions, committed branches and
// mispredict flushes over a measurement window that closes on a stable WFI.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   commit_valid_1/2            ROB commit slot valid
//   commit_flushed_1/2          committed entry was flushed (not counted)
//   commit_branch_1/2           committed entry is a branch
//   must_flush                  decode mispredict flush pulse
//   wfi_a, wfi_b                decoder A/B sees WFI
//   start_i                     zero counters and open the window
//   clear_i                     zero counters and return to IDLE (wins over start_i)
//   rd_req_i, rd_sel_i          read request, counter select (cyc/instr/branch/mispred)
//   rd_valid_o, rd_data_o       one-cycle read response, data held otherwise
//   state_o, done_o             0 IDLE, 1 RUN, 2 DONE; done_o high in DONE
module perf_monitor #(
    parameter int unsigned CYC_W    = 64,
    parameter int unsigned EVT_W    = 32,
    parameter int unsigned WFI_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit_valid_1,
    input  logic             commit_valid_2,
    input  logic             commit_flushed_1,
    input  logic             commit_flushed_2,
    input  logic             commit_branch_1,
    input  logic             commit_branch_2,
    input  logic             must_flush,
    input  logic             wfi_a,
    input  logic             wfi_b,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             rd_req_i,
    input  logic [1:0]       rd_sel_i,
    output logic             rd_valid_o,
    output logic [CYC_W-1:0] rd_data_o,
    output logic [1:0]       state_o,
    output logic             done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int unsigned WW = $clog2(WFI_HOLD + 1);
    localparam logic [WW-1:0] HOLD = WW'(WFI_HOLD);

    logic [1:0]       state_q, state_d;
    logic             done_q, done_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [EVT_W-1:0] ins_q, ins_d;
    logic [EVT_W-1:0] br_q, br_d;
    logic [EVT_W-1:0] mp_q, mp_d;
    logic [WW-1:0]    wfi_q, wfi_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CYC_W-1:0] rd_data_q, rd_data_d;

    logic       q1, q2, b1, b2;
    logic [1:0] ins_inc, br_inc;

    // Saturating add of 0..2; the extra carry bit flags overflow.
    function automatic logic [EVT_W-1:0] evt_add(
        input logic [EVT_W-1:0] v,
        input logic [1:0]       inc
    );
        logic [EVT_W:0] s;
        s = {1'b0, v} + (EVT_W + 1)'(inc);
        evt_add = s[EVT_W] ? {EVT_W{1'b1}} : s[EVT_W-1:0];
    endfunction

    assign q1 = commit_valid_1 & ~commit_flushed_1;
    assign q2 = commit_valid_2 & ~commit_flushed_2;
    assign b1 = q1 & commit_branch_1;
    assign b2 = q2 & commit_branch_2;

    assign ins_inc = {1'b0, q1} + {1'b0, q2};
    assign br_inc  = {1'b0, b1} + {1'b0, b2};

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        br_d    = br_q;
        mp_d    = mp_q;
        wfi_d   = '0;
        if (clear_i) begin
            state_d = S_IDLE;
            cyc_d   = '0;
            ins_d   = '0;
            br_d    = '0;
            mp_d    = '0;
        end else if (start_i) begin
            state_d = S_RUN;
            cyc_d   = '0;
            ins_d   = '0;
            br_d    = '0;
            mp_d    = '0;
        end else if (state_q == S_RUN) begin
            cyc_d = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
            ins_d = evt_add(ins_q, ins_inc);
            br_d  = evt_add(br_q, br_inc);
            mp_d  = evt_add(mp_q, {1'b0, must_flush});
            // wfi_q never exceeds HOLD-1 while in RUN, so +1 cannot overflow.
            if (wfi_a | wfi_b) begin
                wfi_d = wfi_q + WW'(1);
            end
            if (wfi_d == HOLD) begin
                state_d = S_DONE;
                wfi_d   = '0;
            end
        end
    end

    assign done_d = (state_d == S_DONE);

    logic [CYC_W-1:0] ins_x, br_x, mp_x;

    always_comb begin
        ins_x = '0;
        br_x  = '0;
        mp_x  = '0;
        ins_x[EVT_W-1:0] = ins_q;
        br_x[EVT_W-1:0]  = br_q;
        mp_x[EVT_W-1:0]  = mp_q;
    end

    // Reads return the pre-edge counter value.
    always_comb begin
        rd_valid_d = rd_req_i;
        rd_data_d  = rd_data_q;
        if (rd_req_i) begin
            case (rd_sel_i)
                2'd0:    rd_data_d = cyc_q;
                2'd1:    rd_data_d = ins_x;
                2'd2:    rd_data_d = br_x;
                default: rd_data_d = mp_x;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            cyc_q      <= '0;
            ins_q      <= '0;
            br_q       <= '0;
            mp_q       <= '0;
            wfi_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            cyc_q      <= cyc_d;
            ins_q      <= ins_d;
            br_q       <= br_d;
            mp_q       <= mp_d;
            wfi_q      <= wfi_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign state_o    = state_q;
    assign done_o     = done_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: two perf_monitor instances (default widths, and a narrow
// EVT_W=4/CYC_W=8/WFI_HOLD=1 copy) checked against a behavioural model.
module tb_perf_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cv1 = 0, cv2 = 0, cf1 = 0, cf2 = 0, cb1 = 0, cb2 = 0;
    logic mf = 0, wa = 0, wb = 0;
    logic start = 0, clear = 0, rd_req = 0;
    logic [1:0] rd_sel = 0;

    logic        rv0, rv1, dn0, dn1;
    logic [63:0] rd0;
    logic [7:0]  rd1;
    logic [1:0]  st0, st1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    perf_monitor u0 (
        .clk(clk), .rst_n(rst_n),
        .commit_valid_1(cv1), .commit_valid_2(cv2),
        .commit_flushed_1(cf1), .commit_flushed_2(cf2),
        .commit_branch_1(cb1), .commit_branch_2(cb2),
        .must_flush(mf), .wfi_a(wa), .wfi_b(wb),
        .start_i(start), .clear_i(clear),
        .rd_req_i(rd_req), .rd_sel_i(rd_sel),
        .rd_valid_o(rv0), .rd_data_o(rd0),
        .state_o(st0), .done_o(dn0)
    );

    perf_monitor #(.CYC_W(8), .EVT_W(4), .WFI_HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .commit_valid_1(cv1), .commit_valid_2(cv2),
        .commit_flushed_1(cf1), .commit_flushed_2(cf2),
        .commit_branch_1(cb1), .commit_branch_2(cb2),
        .must_flush(mf), .wfi_a(wa), .wfi_b(wb),
        .start_i(start), .clear_i(clear),
        .rd_req_i(rd_req), .rd_sel_i(rd_sel),
        .rd_valid_o(rv1), .rd_data_o(rd1),
        .state_o(st1), .done_o(dn1)
    );

    // Behavioural model: per instance, counters [cyc, instr, branch, mispred].
    logic [63:0] m_cnt [2][4];
    int          m_st  [2];
    int          m_run [2];
    logic [63:0] cmax  [2];
    logic [63:0] emax  [2];
    int          hold  [2];

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] last0 = 0;
    logic [63:0] last1 = 0;

    function automatic logic [63:0] sadd(input logic [63:0] a,
                                         input int unsigned inc,
                                         input logic [63:0] mx);
        if (mx - a < 64'(inc)) return mx;
        return a + 64'(inc);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
            m_st[i]  = 0;
            m_run[i] = 0;
        end
    endtask

    task automatic model_step();
        int unsigned qa, qb, ba, bb;
        qa = (cv1 && !cf1) ? 1 : 0;
        qb = (cv2 && !cf2) ? 1 : 0;
        ba = (qa == 1 && cb1) ? 1 : 0;
        bb = (qb == 1 && cb2) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            if (clear || start) begin
                for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
                m_run[i] = 0;
                m_st[i]  = clear ? 0 : 1;
            end else if (m_st[i] == 1) begin
                m_cnt[i][0] = sadd(m_cnt[i][0], 1, cmax[i]);
                m_cnt[i][1] = sadd(m_cnt[i][1], qa + qb, emax[i]);
                m_cnt[i][2] = sadd(m_cnt[i][2], ba + bb, emax[i]);
                m_cnt[i][3] = sadd(m_cnt[i][3], mf ? 1 : 0, emax[i]);
                m_run[i] = (wa || wb) ? m_run[i] + 1 : 0;
                if (m_run[i] >= hold[i]) begin
                    m_st[i]  = 2;
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        if (rd_req && rst_n) begin
            q0.push_back(m_cnt[0][rd_sel]);
            q1.push_back(m_cnt[1][rd_sel]);
        end
        model_step();
        @(posedge clk);
        #1;
        start  = 0;
        clear  = 0;
        rd_req = 0;
    endtask

    task automatic idle_in();
        cv1 = 0; cv2 = 0; cf1 = 0; cf2 = 0; cb1 = 0; cb2 = 0;
        mf = 0; wa = 0; wb = 0;
    endtask

    task automatic chk_state(input string tag);
        check({tag, " state0"}, 64'(st0), 64'(m_st[0]));
        check({tag, " done0"}, 64'(dn0), 64'(m_st[0] == 2));
        check({tag, " state1"}, 64'(st1), 64'(m_st[1]));
        check({tag, " done1"}, 64'(dn1), 64'(m_st[1] == 2));
    endtask

    task automatic read_all();
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            rd_req = 1;
            tick();
        end
        tick();
    endtask

    task automatic chk_zero_out(input string tag);
        check({tag, " rv0"}, 64'(rv0), 0);
        check({tag, " rd0"}, rd0, 0);
        check({tag, " st0"}, 64'(st0), 0);
        check({tag, " dn0"}, 64'(dn0), 0);
        check({tag, " rv1"}, 64'(rv1), 0);
        check({tag, " rd1"}, 64'(rd1), 0);
        check({tag, " st1"}, 64'(st1), 0);
        check({tag, " dn1"}, 64'(dn1), 0);
    endtask

    // Scoreboard monitor: pops an expectation whenever a read response shows.
    always @(negedge clk) begin
        if (!rst_n) begin
            last0 = 0;
            last1 = 0;
        end else begin
            if (rv0) begin
                if (q0.size() == 0) check("rd0 unexpected valid", 1, 0);
                else begin
                    last0 = q0.pop_front();
                    check("rd0 data", rd0, last0);
                end
            end else check("rd0 hold", rd0, last0);
            if (rv1) begin
                if (q1.size() == 0) check("rd1 unexpected valid", 1, 0);
                else begin
                    last1 = q1.pop_front();
                    check("rd1 data", 64'(rd1), last1);
                end
            end else check("rd1 hold", 64'(rd1), last1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cmax[0] = '1;        emax[0] = 64'hFFFF_FFFF; hold[0] = 4;
        cmax[1] = 64'd255;   emax[1] = 64'd15;        hold[1] = 1;
        model_reset();

        // Reset and idle commits
        repeat (2) @(posedge clk);
        #1;
        chk_zero_out("reset");
        rst_n = 1;
        cv1 = 1; cv2 = 1; cb1 = 1; mf = 1;
        repeat (5) tick();
        idle_in();
        read_all();
        chk_state("idle");

        // Dual commit then WFI close
        start = 1;
        tick();
        chk_state("start");
        cv1 = 1; cv2 = 1;
        repeat (10) tick();
        cv1 = 0; cv2 = 0; wa = 1;
        repeat (3) tick();
        chk_state("wfi3");
        tick();
        chk_state("wfi4");
        idle_in();
        read_all();
        chk_state("dual");

        // Qualification
        start = 1;
        tick();
        cv1 = 1; cf1 = 1; cb1 = 1;
        tick();
        idle_in();
        cv2 = 1; cb2 = 1;
        tick();
        idle_in();
        repeat (3) begin
            mf = 1; tick();
            mf = 0; tick();
        end
        read_all();
        chk_state("qual");

        // WFI filter
        start = 1;
        tick();
        wb = 1;
        repeat (3) tick();
        wb = 0;
        tick();
        chk_state("wfi filt");
        wb = 1;
        repeat (4) tick();
        wb = 0;
        chk_state("wfi close");
        cv1 = 1; cv2 = 1; cb1 = 1; mf = 1;
        repeat (3) tick();
        idle_in();
        read_all();

        // Saturation
        start = 1;
        tick();
        cv1 = 1; cv2 = 1;
        repeat (10) tick();
        read_all();
        repeat (3) tick();
        read_all();
        idle_in();

        // start and clear together in RUN
        start = 1;
        tick();
        cv1 = 1; mf = 1;
        repeat (3) tick();
        start = 1; clear = 1;
        tick();
        chk_state("prio");
        read_all();
        idle_in();

        // Randomized windows
        for (int n = 0; n < 600; n++) begin
            cv1 = 1'($urandom_range(0, 1));
            cv2 = 1'($urandom_range(0, 1));
            cf1 = ($urandom_range(0, 3) == 0);
            cf2 = ($urandom_range(0, 3) == 0);
            cb1 = 1'($urandom_range(0, 1));
            cb2 = 1'($urandom_range(0, 1));
            mf  = ($urandom_range(0, 3) == 0);
            wa  = ($urandom_range(0, 9) == 0);
            wb  = ($urandom_range(0, 9) == 0);
            start  = ($urandom_range(0, 39) == 0);
            clear  = ($urandom_range(0, 99) == 0);
            rd_req = ($urandom_range(0, 2) == 0);
            rd_sel = 2'($urandom_range(0, 3));
            tick();
            chk_state("rand");
        end
        idle_in();
        tick();
        tick();

        // Asynchronous reset mid-RUN
        start = 1;
        tick();
        cv1 = 1; cv2 = 1;
        rd_sel = 1; rd_req = 1;
        tick();
        tick();
        tick();
        #2;
        rst_n = 0;
        #1;
        chk_zero_out("async rst");
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1;
        tick();
        read_all();
        chk_state("post rst");
        idle_in();
        tick();
        tick();
        check("rd0 queue drained", 64'(q0.size()), 0);
        check("rd1 queue drained", 64'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
